// File: rtl/dmem_arb_pkg.sv
// Shared types and sizes for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W    = 10;
  localparam int DATA_W    = 32;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Everything about an accepted request that the ACCESS cycle needs.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dmem_arb_sel.sv
// Winner selection between the two requesters.
// Build option: DMEM_ARB_RR_EN selects round-robin on ties; otherwise
// port 0 has fixed priority and the last-winner input is ignored.
module dmem_arb_sel
  import dmem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 last_i,
  output logic                 any_o,
  output logic                 win_o
);

  // A single requester always wins; only the tie depends on the policy.
  always_comb begin
    any_o = |req_i;
    win_o = 1'b0;
    if (req_i == 2'b10) begin
      win_o = 1'b1;
    end else if (req_i == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      win_o = ~last_i;
`else
      win_o = 1'b0;
`endif
    end
  end

`ifndef DMEM_ARB_RR_EN
  logic unused_last;
  assign unused_last = last_i;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 1024 x 32 data memory.
// Handshake: a port holds req_i (with we/addr/wdata stable) until its gnt_o
// bit pulses; gnt_o is combinational in IDLE/RESP, the memory is driven in
// the following ACCESS cycle, and resp_valid_o pulses one cycle after that.
// Build option: DMEM_ARB_RR_EN enables round-robin tie breaking.
module dmem_arbiter
  import dmem_arb_pkg::*;
(
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [NUM_PORTS-1:0]             we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]             gnt_o,
  output logic [NUM_PORTS-1:0]             resp_valid_o,
  output logic [DATA_W-1:0]                resp_rdata_o,
  output logic [ADDR_W-1:0]                mem_addr_o,
  output logic [DATA_W-1:0]                mem_wdata_o,
  output logic                             mem_wren_o,
  input  logic [DATA_W-1:0]                mem_rdata_i,
  output state_t                           dbg_state_o
);

  state_t state_q, state_d;
  req_t   req_q;
  logic   win_q;
  logic   last_winner;
  logic   any_req, win, accept;

  dmem_arb_sel u_sel (
    .req_i  (req_i),
    .last_i (last_winner),
    .any_o  (any_req),
    .win_o  (win)
  );

`ifdef DMEM_ARB_RR_EN
  logic last_q;

  // Remember who won the latest grant; port 1 after reset so port 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= win;
    end
  end

  assign last_winner = last_q;
`else
  assign last_winner = 1'b1;
`endif

  // Memory address/data come straight from the request register, so they
  // hold their last value outside ACCESS.
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign dbg_state_o = state_q;

  // Next state, grant, response pulse and write enable.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    gnt_o        = '0;
    resp_valid_o = '0;
    mem_wren_o   = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (state_q == RESP) begin
          resp_valid_o[win_q] = 1'b1;
        end
        if (any_req && !rst_i) begin
          accept     = 1'b1;
          gnt_o[win] = 1'b1;
          state_d    = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // Reset in this cycle suppresses the write.
        mem_wren_o = req_q.we & ~rst_i;
        state_d    = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accepted request and captured read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_q        <= '0;
      win_q        <= 1'b0;
      resp_rdata_o <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q.we    <= we_i[win];
        req_q.addr  <= addr_i[win];
        req_q.wdata <= wdata_i[win];
        win_q       <= win;
      end
      if (state_q == ACCESS) begin
        resp_rdata_o <= req_q.we ? '0 : mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a memory model and response scoreboard.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic                     clk;
  logic                     rst;
  logic [1:0]               req;
  logic [1:0]               we;
  logic [1:0][ADDR_W-1:0]   addr;
  logic [1:0][DATA_W-1:0]   wdata;
  logic [1:0]               gnt;
  logic [1:0]               resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     mem_wren;
  logic [DATA_W-1:0]        mem_rdata;
  state_t                   dbg_state;

  dmem_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .gnt_o        (gnt),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wren_o   (mem_wren),
    .mem_rdata_i  (mem_rdata),
    .dbg_state_o  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge, bench preload port.
  logic [DATA_W-1:0] mem [0:1023];
  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [DATA_W-1:0] pl_data;
  int                wren_cnt;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  always @(posedge clk) begin
    if (mem_wren) wren_cnt <= wren_cnt + 1;
  end

  // Scoreboard
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        port_q[$];
  logic [DATA_W-1:0] ref_mem [0:1023];
  int                errors;
  int                checks;
  logic [1:0]        granted;
  logic              hold;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (!hold) req = req & ~granted;
    granted = '0;
  endtask

  task automatic drive(input int p, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    req[p]   = 1'b1;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Settle, then score any response and record any grant.
  task automatic sample();
    logic [1:0] oh;
    #1;
    if (resp_valid !== 2'b00) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed valid=%b expected none", resp_valid);
      end
      if (exp_q.size() > 0) begin
        check("sb_port", 32'(resp_valid), 32'(port_q.pop_front()));
        check("sb_rdata", resp_rdata, exp_q.pop_front());
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (gnt[p]) begin
        granted[p] = 1'b1;
        oh = '0;
        oh[p] = 1'b1;
        port_q.push_back(oh);
        if (we[p]) begin
          exp_q.push_back('0);
          ref_mem[addr[p]] = wdata[p];
        end else begin
          exp_q.push_back(ref_mem[addr[p]]);
        end
      end
    end
  endtask

  logic [DATA_W-1:0] old3;
  int                w0;
  logic [1:0]        exp_gnt;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    errors = 0; checks = 0; granted = '0; hold = 1'b0; wren_cnt = 0;

    // Reset and preload
    @(negedge clk);
    preload(10'd5,    32'hDEADBEEF);
    preload(10'd3,    32'h0BADF00D);
    preload(10'd7,    $urandom);
    preload(10'd9,    $urandom);
    preload(10'd10,   $urandom);
    preload(10'd1023, 32'h0);
    req = 2'b11;
    sample();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_addr", 32'(mem_addr), 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wren", 32'(mem_wren), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    req = 2'b00;
    tick();
    rst = 1'b0;

    // Single read of mem[5] by port 0
    drive(0, 1'b0, 10'd5, 32'h0);
    sample();
    check("t1_gnt", 32'(gnt), 32'h1);
    tick(); sample();
    check("t1_state", 32'(dbg_state), 32'(ACCESS));
    check("t1_addr", 32'(mem_addr), 32'd5);
    check("t1_wren", 32'(mem_wren), 32'h0);
    tick(); sample();
    check("t1_valid", 32'(resp_valid), 32'h1);
    check("t1_rdata", resp_rdata, 32'hDEADBEEF);
    tick(); sample();

    // Port 1 writes addr 1023, then port 0 reads it back
    w0 = wren_cnt;
    drive(1, 1'b1, 10'd1023, 32'h12345678);
    sample();
    check("t2_gnt", 32'(gnt), 32'h2);
    tick(); sample();
    check("t2_wren", 32'(mem_wren), 32'h1);
    check("t2_addr", 32'(mem_addr), 32'd1023);
    check("t2_wdata", mem_wdata, 32'h12345678);
    tick(); sample();
    check("t2_wren_off", 32'(mem_wren), 32'h0);
    check("t2_valid", 32'(resp_valid), 32'h2);
    check("t2_wr_rdata", resp_rdata, 32'h0);
    tick(); sample();
    check("t2_wren_cnt", 32'(wren_cnt - w0), 32'd1);
    drive(0, 1'b0, 10'd1023, 32'h0);
    sample();
    tick(); sample();
    tick(); sample();
    check("t2_rd_rdata", resp_rdata, 32'h12345678);
    tick(); sample();

    // Contention from reset: both ports request continuously
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete(); port_q.delete();
    hold = 1'b1;
    drive(0, 1'b0, 10'd5, 32'h0);
    drive(1, 1'b0, 10'd7, 32'h0);
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i % 2 == 1) exp_gnt = 2'b00;
`ifdef DMEM_ARB_RR_EN
      else exp_gnt = (i % 4 == 0) ? 2'b01 : 2'b10;
`else
      else exp_gnt = 2'b01;
`endif
      check("t3_gnt", 32'(gnt), 32'(exp_gnt));
      tick();
    end
    hold = 1'b0;
    req = 2'b00;
    sample();
    tick(); sample();

    // Reset during the ACCESS cycle of a write to addr 3
    old3 = ref_mem[3];
    drive(0, 1'b1, 10'd3, 32'hFFFFFFFF);
    sample();
    check("t4_gnt", 32'(gnt), 32'h1);
    tick();
    rst = 1'b1;
    sample();
    check("t4_state", 32'(dbg_state), 32'(ACCESS));
    check("t4_wren", 32'(mem_wren), 32'h0);
    tick();
    rst = 1'b0;
    exp_q.delete(); port_q.delete();
    ref_mem[3] = old3;
    sample();
    check("t4_valid", 32'(resp_valid), 32'h0);
    check("t4_gnt0", 32'(gnt), 32'h0);
    check("t4_rdata", resp_rdata, 32'h0);
    check("t4_addr", 32'(mem_addr), 32'h0);
    check("t4_wdata", mem_wdata, 32'h0);
    check("t4_state_idle", 32'(dbg_state), 32'(IDLE));
    tick(); sample();
    check("t4_valid_late", 32'(resp_valid), 32'h0);
    drive(0, 1'b0, 10'd3, 32'h0);
    sample();
    tick(); sample();
    tick(); sample();
    check("t4_mem3", resp_rdata, 32'h0BADF00D);
    tick(); sample();

    // Back-to-back: port 0 request lands in RESP of a port 1 read
    drive(1, 1'b0, 10'd9, 32'h0);
    sample();
    check("t5_gnt1", 32'(gnt), 32'h2);
    tick(); sample();
    tick();
    drive(0, 1'b0, 10'd10, 32'h0);
    sample();
    check("t5_valid1", 32'(resp_valid), 32'h2);
    check("t5_gnt0", 32'(gnt), 32'h1);
    tick(); sample();
    tick(); sample();
    check("t5_valid0", 32'(resp_valid), 32'h1);
    tick(); sample();
    tick(); sample();
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
